// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx: valid/ready byte input, 8N1 serial output, fixed baud divider |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic       uart_ready,
  output logic       uart_out,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
  logic [7:0]       shift_q,    shift_d;
  logic             uart_out_q, uart_out_d;
  logic             bit_done;

  assign bit_done   = (clk_cnt_q == CNT_LAST);
  assign uart_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign uart_out   = uart_out_q;

  // uart_out_d tracks the level of the next state so the registered line
  // changes on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    clk_cnt_d  = clk_cnt_q;
    shift_d    = shift_q;
    uart_out_d = uart_out_q;
    case (state_q)
      IDLE: begin
        uart_out_d = 1'b1;
        if (uart_valid) begin
          shift_d    = uart_data;
          clk_cnt_d  = '0;
          state_d    = START;
          uart_out_d = 1'b0;
        end
      end
      START: begin
        uart_out_d = 1'b0;
        if (bit_done) begin
          clk_cnt_d  = '0;
          bit_cnt_d  = 3'd0;
          state_d    = DATA;
          uart_out_d = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        uart_out_d = shift_q[0];
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = STOP;
            uart_out_d = 1'b1;
          end else begin
            uart_out_d = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        uart_out_d = 1'b1;
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        uart_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      clk_cnt_q  <= '0;
      shift_q    <= 8'd0;
      uart_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      shift_q    <= shift_d;
      uart_out_q <= uart_out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx: directed self-checking bench for uart_tx (CLKS_PER_BIT=4) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       uart_ready;
  logic       uart_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // UART receive monitor: {stop_bit, data_byte} per decoded frame
  logic       mon_en = 1'b0;
  logic       in_frame = 1'b0;
  int         mcnt = 0;
  logic [7:0] rx_byte = 8'd0;
  logic [8:0] rx_q[$];

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .uart_out   (uart_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!in_frame) begin
        if (uart_out == 1'b0) begin
          in_frame <= 1'b1;
          mcnt     <= 1;
        end
      end else begin
        mcnt <= mcnt + 1;
        if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2)
          rx_byte[(mcnt - 6) / 4] <= uart_out;
        if (mcnt == 38)
          rx_q.push_back({uart_out, rx_byte});
        if (mcnt == 39)
          in_frame <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    uart_valid = 1'b1;
    uart_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (uart_out !== 1'b1 || busy !== 1'b0 || uart_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset cyc%0d: out=%b busy=%b ready=%b, want out=1 busy=0 ready=1",
                 i, uart_out, busy, uart_ready);
      end
    end
    uart_valid = 1'b0;
    rst        = 1'b0;
    tick();
    checks++;
    if (uart_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: out=%b busy=%b, want out=1 busy=0", uart_out, busy);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame      = {1'b1, 8'h7B, 1'b0};
    uart_data  = 8'h7B;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    for (int i = 0; i < 10 * C; i++) begin
      checks++;
      if (uart_out !== frame[i / C] || busy !== 1'b1 || uart_ready !== 1'b0) begin
        failures++;
        $display("FAIL single_byte cyc%0d: out=%b busy=%b ready=%b, want out=%b busy=1 ready=0",
                 i, uart_out, busy, uart_ready, frame[i / C]);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || uart_ready !== 1'b1 || uart_out !== 1'b1) begin
      failures++;
      $display("FAIL single_byte_end: busy=%b ready=%b out=%b, want busy=0 ready=1 out=1",
               busy, uart_ready, uart_out);
    end
  endtask

  task automatic test_data_stability();
    logic [9:0] frame;
    frame      = {1'b1, 8'h00, 1'b0};
    uart_data  = 8'h00;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    for (int i = 0; i < 10 * C; i++) begin
      uart_data = (i % 2 == 0) ? 8'hFF : 8'hAA;
      checks++;
      if (uart_out !== frame[i / C]) begin
        failures++;
        $display("FAIL data_stability cyc%0d: out=%b, want %b", i, uart_out, frame[i / C]);
      end
      tick();
    end
    uart_data = 8'h00;
    checks++;
    if (uart_ready !== 1'b1) begin
      failures++;
      $display("FAIL data_stability_end: ready=%b, want 1", uart_ready);
    end
  endtask

  task automatic test_back_to_back();
    string msg;
    int    idx;
    int    last_acc;
    int    budget;
    logic  acc;
    msg      = "{\"T\":1,\"L\":0.000,\"R\":0.000}\n";
    idx      = 0;
    last_acc = -1;
    budget   = 0;
    rx_q.delete();
    mon_en   = 1'b1;
    while ((idx < msg.len() || rx_q.size() < msg.len()) && budget < 41 * 28 + 200) begin
      uart_valid = (idx < msg.len());
      uart_data  = (idx < msg.len()) ? msg[idx] : 8'h00;
      acc        = uart_valid && uart_ready;
      tick();
      budget++;
      if (acc) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 41) begin
            failures++;
            $display("FAIL b2b_gap byte%0d: gap=%0d, want 41", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
      end
    end
    uart_valid = 1'b0;
    repeat (2) tick();
    mon_en = 1'b0;
    checks++;
    if (idx != msg.len() || rx_q.size() != msg.len()) begin
      failures++;
      $display("FAIL b2b_count: accepted=%0d decoded=%0d, want %0d", idx, rx_q.size(), msg.len());
    end
    for (int i = 0; i < msg.len() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {1'b1, msg[i]}) begin
        failures++;
        $display("FAIL b2b_byte%0d: got stop=%b data=%h, want stop=1 data=%h",
                 i, rx_q[i][8], rx_q[i][7:0], msg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] frame;
    uart_data  = 8'hA5;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    repeat (4 * C + 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (uart_out !== 1'b1 || uart_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame: out=%b ready=%b busy=%b, want out=1 ready=1 busy=0",
               uart_out, uart_ready, busy);
    end
    frame      = {1'b1, 8'h55, 1'b0};
    uart_data  = 8'h55;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    for (int i = 0; i < 10 * C; i++) begin
      checks++;
      if (uart_out !== frame[i / C] || busy !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_0x55 cyc%0d: out=%b busy=%b, want out=%b busy=1",
                 i, uart_out, busy, frame[i / C]);
      end
      tick();
    end
    checks++;
    if (uart_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_end: ready=%b, want 1", uart_ready);
    end
  endtask

  task automatic test_valid_low_idle();
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (uart_out !== 1'b1 || busy !== 1'b0 || uart_ready !== 1'b1) begin
        failures++;
        $display("FAIL valid_low cyc%0d: out=%b busy=%b ready=%b, want out=1 busy=0 ready=1",
                 i, uart_out, busy, uart_ready);
      end
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    test_reset();
    test_single_byte();
    test_data_stability();
    test_back_to_back();
    test_reset_mid_frame();
    test_valid_low_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
